pipelined_rca: RTL

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 16-bit chained-nibble adder.

---
 rtl/pipelined_rca_pkg.sv | 26 ++
 rtl/rca_chunk_stage.sv | 33 +++
 rtl/pipelined_rca.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits per pipeline stage
//   STAGES                : stage count of the default configuration
//   rcaMode_e             : add/sub mode encoding carried by the subMode input
//   numStages / chunkLo   : stage count and low bit index of a chunk
package pipelined_rca_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
  localparam int STAGES    = DEF_WIDTH / DEF_CHUNK;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } rcaMode_e;

  function automatic int numStages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Lowest bit index of chunk k.
  function automatic int chunkLo(input int k, input int chunk);
    return k * chunk;
  endfunction

endpackage

// File: rtl/rca_chunk_stage.sv
// CHUNK-bit combinational ripple of full adders; one instance per pipeline stage.
//   a, b  : chunk operands (b already inverted for subtraction)
//   cIn   : carry into bit 0 of the chunk
//   s     : chunk sum
//   cOut  : carry out of the chunk MSB
//   cMsb  : carry into the chunk MSB (used for signed overflow on the top chunk)
module rca_chunk_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cIn,
  output logic [CHUNK-1:0] s,
  output logic             cOut,
  output logic             cMsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cIn;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cOut = c[CHUNK];
  assign cMsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// Each CHUNK-bit slice resolves in its own stage; the carry is registered between
// stages, untouched upper operand chunks ride along in skew registers and finished
// lower sum chunks ride along in deskew registers.
//   Clk, Rs (async, active-low), En (global enable, 0 freezes everything)
//   inValid / inReady   : operand handshake (inReady = advance, combinational)
//   a, b, cIn, subMode  : operands; subMode=1 computes a-b-cIn
//   outValid / outReady : result handshake
//   sUm, cOut, oVf      : result, carry out of MSB (sub: 1 = no borrow), signed overflow
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             Clk,
  input  logic             Rs,
  input  logic             En,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             subMode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sUm,
  output logic             cOut,
  output logic             oVf
);

  localparam int NSTG = numStages(WIDTH, CHUNK);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : gBadParam
    $error("pipelined_rca: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic             advance;
  rcaMode_e         mode;
  logic [WIDTH-1:0] bEff;
  logic             cEff;

  // Row k of these arrays is what stage k sees at its input.
  logic [CHUNK-1:0] rowInA [NSTG][NSTG];
  logic [CHUNK-1:0] rowInB [NSTG][NSTG];
  logic [CHUNK-1:0] rowInS [NSTG][NSTG];
  logic             stCin  [NSTG];
  logic             stVin  [NSTG];

  // Chunk adder results per stage.
  logic [CHUNK-1:0] stS    [NSTG];
  logic             stCout [NSTG];
  logic             stCmsb [NSTG];

  // Inter-stage registers (rows 0..NSTG-2); the last stage writes the outputs.
  logic [CHUNK-1:0] aSkew   [NSTG][NSTG];
  logic [CHUNK-1:0] bSkew   [NSTG][NSTG];
  logic [CHUNK-1:0] sDeskew [NSTG][NSTG];
  logic             carryQ  [NSTG];
  logic             vldQ    [NSTG];

  logic [WIDTH-1:0] sumNext;

  // No bubble collapsing: the whole pipe moves only when the output slot frees up.
  assign advance = En & (outReady | ~outValid);
  assign inReady = advance;

  // Subtraction is a + ~b + ~cIn, folded in once at acceptance.
  assign mode = rcaMode_e'(subMode);
  assign bEff = (mode == MODE_SUB) ? ~b : b;
  assign cEff = (mode == MODE_SUB) ? ~cIn : cIn;

  for (genvar k = 0; k < NSTG; k++) begin : gStage
    if (k == 0) begin : gFirst
      for (genvar c = 0; c < NSTG; c++) begin : gChunk
        assign rowInA[0][c] = a[chunkLo(c, CHUNK) +: CHUNK];
        assign rowInB[0][c] = bEff[chunkLo(c, CHUNK) +: CHUNK];
        assign rowInS[0][c] = '0;
      end
      assign stCin[0] = cEff;
      assign stVin[0] = inValid;
    end else begin : gNext
      assign rowInA[k] = aSkew[k-1];
      assign rowInB[k] = bSkew[k-1];
      assign rowInS[k] = sDeskew[k-1];
      assign stCin[k]  = carryQ[k-1];
      assign stVin[k]  = vldQ[k-1];
    end

    rca_chunk_stage #(.CHUNK(CHUNK)) uChunk (
      .a    (rowInA[k][k]),
      .b    (rowInB[k][k]),
      .cIn  (stCin[k]),
      .s    (stS[k]),
      .cOut (stCout[k]),
      .cMsb (stCmsb[k])
    );
  end

  // Final stage: lower chunks come from the deskew row, top chunk from the last adder.
  always_comb begin
    sumNext = '0;
    for (int c = 0; c < NSTG; c++) begin
      sumNext[chunkLo(c, CHUNK) +: CHUNK] = (c == NSTG-1) ? stS[NSTG-1] : rowInS[NSTG-1][c];
    end
  end

  // ---- stage registers 0..NSTG-2: data path (no reset) ----
  always_ff @(posedge Clk) begin
    if (advance) begin
      for (int k = 0; k < NSTG-1; k++) begin
        aSkew[k]  <= rowInA[k];
        bSkew[k]  <= rowInB[k];
        carryQ[k] <= stCout[k];
        for (int c = 0; c < NSTG; c++) begin
          sDeskew[k][c] <= (c == k) ? stS[k] : rowInS[k][c];
        end
      end
    end
  end

  // ---- valid chain and final output stage ----
  always_ff @(posedge Clk or negedge Rs) begin
    if (!Rs) begin
      for (int k = 0; k < NSTG; k++) begin
        vldQ[k] <= 1'b0;
      end
      outValid <= 1'b0;
      sUm      <= '0;
      cOut     <= 1'b0;
      oVf      <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSTG-1; k++) begin
        vldQ[k] <= stVin[k];
      end
      outValid <= stVin[NSTG-1];
      sUm      <= sumNext;
      cOut     <= stCout[NSTG-1];
      oVf      <= stCout[NSTG-1] ^ stCmsb[NSTG-1];
    end
  end

endmodule
